// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (receiver FSM states, widths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_sipo.sv
// ============================================================================
// Module      : SIPO
// Description : Serial-in parallel-out register, shifts right with MSB in so
//               an LSB-first stream lands in natural bit order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module SIPO
    import uart_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift_en,
    input  logic                   d_in,
    output logic [UART_DATA_W-1:0] d_out
);

    logic [UART_DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (shift_en) begin
            r_data <= {d_in, r_data[UART_DATA_W-1:1]};
        end
    end

    assign d_out = r_data;

endmodule : SIPO

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with mid-bit sampling and a one-entry
//               valid/ready output holding register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   rx_clk,
    input  logic                   rx_rst,
    input  logic                   rx_en,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] rx_o_data,
    output logic                   rx_o_data_valid,
    input  logic                   rx_i_ready,
    output logic                   rx_o_frame_err,
    output logic                   rx_o_overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_W);

    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(UART_DATA_W - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);

    logic                   r_sync1;
    logic                   r_rx_s;
    logic                   r_rx_prev;
    rx_state_t              r_state;
    rx_state_t              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [IDX_W-1:0]       w_bit_idx_nxt;
    logic                   w_start_det;
    logic                   w_shift;
    logic                   w_stop_sample;
    logic                   w_commit;
    logic [UART_DATA_W-1:0] w_shift_data;
    logic [UART_DATA_W-1:0] r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    // Two-flop synchroniser plus previous-sample register for edge detect.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            r_sync1   <= UART_IDLE_LVL;
            r_rx_s    <= UART_IDLE_LVL;
            r_rx_prev <= UART_IDLE_LVL;
        end else begin
            r_sync1   <= rx_i;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_start_det = ~r_rx_s & r_rx_prev;

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift       = 1'b0;
        w_stop_sample = 1'b0;

        if (!rx_en) begin
            // Abandon any frame silently; the output register is untouched.
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_bit_idx_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    if (w_start_det) begin
                        w_state_nxt = START;
                    end
                end
                START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        w_cnt_nxt     = '0;
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = r_rx_s ? IDLE : DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        w_cnt_nxt = '0;
                        w_shift   = 1'b1;
                        if (r_bit_idx == c_IDX_LAST) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + c_IDX_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        w_cnt_nxt     = '0;
                        w_stop_sample = 1'b1;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                end
            endcase
        end
    end

    assign w_commit = w_stop_sample & r_rx_s;

    SIPO u_sipo (
        .clk      (rx_clk),
        .rst      (rx_rst),
        .shift_en (w_shift),
        .d_in     (r_rx_s),
        .d_out    (w_shift_data)
    );

    // A consumer transfer on the commit edge frees the slot for the new byte.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_sample & ~r_rx_s;
            r_overrun   <= 1'b0;
            if (w_commit) begin
                if (!r_valid || rx_i_ready) begin
                    r_data  <= w_shift_data;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_o_data       = r_data;
    assign rx_o_data_valid = r_valid;
    assign rx_o_frame_err  = r_frame_err;
    assign rx_o_overrun    = r_overrun;

endmodule : uart_rx

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx against a frame-timing model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int C   = 16;
    localparam int H   = C / 2;
    localparam int LAT = 2 + H + 9 * C;

    typedef struct {
        int         t;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b1;
    logic       rxi   = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] dout;
    logic       dvalid;
    logic       ferr;
    logic       ovr;

    ev_t        evq[$];
    ev_t        ev;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    int         t0;
    bit         cmp_on = 1'b0;
    bit         rnd_on = 1'b0;
    bit         pre_v;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovr   = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .rx_clk          (clk),
        .rx_rst          (rst),
        .rx_en           (en),
        .rx_i            (rxi),
        .rx_o_data       (dout),
        .rx_o_data_valid (dvalid),
        .rx_i_ready      (ready),
        .rx_o_frame_err  (ferr),
        .rx_o_overrun    (ovr)
    );

    // Model: each completed frame becomes one event at E0+LAT; the holding
    // register follows the valid/ready rules from that event list.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            exp_ferr  = 1'b0;
            exp_ovr   = 1'b0;
            evq.delete();
        end else begin
            cyc++;
            pre_v    = exp_valid;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            if (evq.size() > 0 && evq[0].t == cyc) begin
                ev = evq.pop_front();
                if (!ev.ok)                 exp_ferr = 1'b1;
                else if (!pre_v || ready) begin
                    exp_data  = ev.b;
                    exp_valid = 1'b1;
                end else                    exp_ovr = 1'b1;
            end else if (pre_v && ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_valid", 32'(dvalid), 32'(exp_valid));
            chk("cyc_data",  32'(dout),   32'(exp_data));
            chk("cyc_ferr",  32'(ferr),   32'(exp_ferr));
            chk("cyc_ovr",   32'(ovr),    32'(exp_ovr));
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit stopv);
        ev_t e;
        e.t  = cyc + 1 + LAT;
        e.b  = b;
        e.ok = stopv;
        evq.push_back(e);
        rxi = 1'b0;
        repeat (C) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxi = b[k];
            repeat (C) @(negedge clk);
        end
        rxi = stopv;
        repeat (C) @(negedge clk);
    endtask

    // Start bit plus bits below bit_k, then stop half-way through bit_k.
    task automatic send_partial(input logic [7:0] b, input int bit_k);
        rxi = 1'b0;
        repeat (C) @(negedge clk);
        for (int k = 0; k < bit_k; k++) begin
            rxi = b[k];
            repeat (C) @(negedge clk);
        end
        rxi = b[bit_k];
        repeat (H) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxi = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(dvalid), 32'd0);
        chk("rst_data",  32'(dout),   32'd0);
        chk("rst_ferr",  32'(ferr),   32'd0);
        chk("rst_ovr",   32'(ovr),    32'd0);
        cmp_on = 1'b1;
        idle(5);

        // Basic byte, latency pinned to E0+154.
        t0 = cyc + 1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_to(t0 + 153);
                chk("basic_pre", 32'(dvalid), 32'd0);
                @(negedge clk);
                chk("basic_valid", 32'(dvalid), 32'd1);
                chk("basic_data",  32'(dout),   32'hA5);
            end
        join
        idle(10);
        chk("basic_hold", 32'(dvalid), 32'd1);
        drain();
        chk("basic_drain", 32'(dvalid), 32'd0);

        // False start.
        rxi = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * C);
        chk("false_start", 32'(dvalid | ferr), 32'd0);

        // Framing error, then line held low, then a good frame.
        t0 = cyc + 1;
        fork
            send_frame(8'h3C, 1'b0);
            begin
                wait_to(t0 + 154);
                chk("ferr_pulse", 32'(ferr),   32'd1);
                chk("ferr_valid", 32'(dvalid), 32'd0);
                @(negedge clk);
                chk("ferr_one_cycle", 32'(ferr), 32'd0);
            end
        join
        repeat (3 * C) @(negedge clk);
        idle(4);
        send_frame(8'h81, 1'b1);
        idle(4);
        chk("after_ferr_data",  32'(dout),   32'h81);
        chk("after_ferr_valid", 32'(dvalid), 32'd1);
        drain();

        // Overrun: second byte dropped.
        t0 = cyc + 1;
        fork
            begin
                send_frame(8'h55, 1'b1);
                send_frame(8'h19, 1'b1);
            end
            begin
                wait_to(t0 + 10 * C + 154);
                chk("ovr_pulse", 32'(ovr),  32'd1);
                chk("ovr_data",  32'(dout), 32'h55);
            end
        join
        idle(4);
        chk("ovr_keep", 32'(dout), 32'h55);
        drain();

        // Ready at the second commit edge: new byte replaces the drained one.
        t0 = cyc + 1;
        fork
            begin
                send_frame(8'h55, 1'b1);
                send_frame(8'h19, 1'b1);
            end
            begin
                wait_to(t0 + 10 * C + 153);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                chk("swap_data",  32'(dout),   32'h19);
                chk("swap_valid", 32'(dvalid), 32'd1);
                chk("swap_ovr",   32'(ovr),    32'd0);
            end
        join

        // Enable drop mid-frame; the held byte can still be drained.
        send_partial(8'hAA, 3);
        en = 1'b0;
        drain();
        chk("en_drain", 32'(dvalid), 32'd0);
        repeat (4) @(negedge clk);
        rxi = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b1;
        idle(C);
        send_frame(8'h19, 1'b1);
        idle(4);
        chk("en_data", 32'(dout), 32'h19);

        // Asynchronous reset during bit 5 with a byte held.
        send_partial(8'h6B, 5);
        rxi = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(dvalid), 32'd0);
        chk("midrst_data",  32'(dout),   32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        idle(C);
        send_frame(8'hF0, 1'b1);
        idle(4);
        chk("postrst_data", 32'(dout), 32'hF0);
        drain();

        // Randomised frames, gaps, stop bits and ready.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic [7:0] b;
                    bit         s;
                    b = 8'($urandom);
                    s = ($urandom_range(0, 4) != 0);
                    send_frame(b, s);
                    idle(s ? $urandom_range(0, 3) : $urandom_range(2, 6));
                end
                idle(20);
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    ready = ($urandom_range(0, 2) == 0);
                    @(negedge clk);
                end
                ready = 1'b0;
            end
        join
        chk("evq_empty", 32'(evq.size()), 32'd0);

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_rx

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver: the serial-to-parallel counterpart of `uart_tx`. It synchronises an asynchronous serial line and detects 8N1 frames (one start bit, 8 data bits LSB-first, one stop bit) by mid-bit sampling. Each received byte is presented on a valid/ready output port backed by a one-entry holding register. It sits between the pad-side `rx_i` line and the byte-consuming logic.

## Interface
- `CLKS_PER_BIT`, default 16: `rx_clk` cycles per serial bit; must be even and ≥ 4.
- `rx_clk`, input, 1: receiver clock; all state updates on its rising edge.
- `rx_rst`, input, 1: reset. Reset is asynchronous and active-high.
- `rx_en`, input, 1: receiver enable.
- `rx_i`, input, 1: asynchronous serial line; idles high.
- `rx_o_data`, output, 8: received byte.
- `rx_o_data_valid`, output, 1: `rx_o_data` holds an unconsumed byte.
- `rx_i_ready`, input, 1: consumer accepts the byte.
- `rx_o_frame_err`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `rx_o_overrun`, output, 1: one-cycle pulse when a completed byte is dropped.

## Operation
- Reset values:
  - Synchroniser flops and the edge-detect register reset to 1 (idle line).
  - State resets to IDLE; counters reset to 0.
  - `rx_o_data` = 0x00, `rx_o_data_valid` = 0, `rx_o_frame_err` = 0, `rx_o_overrun` = 0.
- `rx_i` passes through a 2-flop synchroniser to give `rx_s`. Start detect is `rx_s` == 0 while the previous `rx_s` == 1 (falling edge only).
- FSM states:
  - IDLE: on start detect with `rx_en` = 1, go to START; bit counter `cnt` = 0.
  - START: after `CLKS_PER_BIT/2` cycles, sample `rx_s`. If 0, go to DATA with `cnt` = 0 and bit index = 0. If 1 (false start), go to IDLE.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register, LSB first. After bit index 7, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`, then go to IDLE.
    - Sample 1: commit the byte to the output register.
    - Sample 0: pulse `rx_o_frame_err` and discard the byte.
- A low line after STOP (break, or a frame error) does not re-arm the receiver. The next frame requires a fresh falling edge.
- Output handshake: a transfer occurs on any rising edge where `rx_o_data_valid` = 1 and `rx_i_ready` = 1. The cycle after the transfer, valid drops unless a commit happens on the same edge.
- Commit while valid = 0, or while valid = 1 and `rx_i_ready` = 1 on the same edge: load the new byte and set valid = 1. No overrun.
- Commit while valid = 1 and `rx_i_ready` = 0: keep the old byte, drop the new one, pulse `rx_o_overrun`.
- `rx_en` = 0:
  - The FSM is forced to IDLE synchronously and any in-flight frame is abandoned without a frame_err pulse.
  - The output register and valid are unaffected, so a held byte can still be drained.
- Asserting `rx_rst` mid-frame returns every register to its reset value immediately. A held byte is lost.

## Timing
- Define E0 as the first `rx_clk` edge that samples `rx_i` low for a start bit.
- START is entered at edge E0+2.
- Sample points:
  - Start bit: edge E0+2+H, where H = `CLKS_PER_BIT/2`.
  - Data bit k: edge E0+2+H+(k+1)·C, where C = `CLKS_PER_BIT`.
  - Stop bit: edge E0+2+H+9C.
- `rx_o_data_valid`, or the frame_err pulse, is registered high at edge E0+2+H+9C. With C = 16 this is E0+154.
- IDLE is re-entered at that same edge, so back-to-back frames are accepted with no idle bit beyond the stop bit.
- `rx_o_frame_err` and `rx_o_overrun` are high for exactly one cycle each.

## Structure
- Package `uart_pkg` holds:
  - The state enum `rx_state_t` = {IDLE, START, DATA, STOP}.
  - `UART_DATA_W` = 8.
  - The idle line level constant, shared with `uart_tx`.
- Sub-module `SIPO`: 8-bit serial-in parallel-out shift register, shifting right with MSB in. Ports: `clk`, `rst`, `shift_en`, `d_in`, `d_out[7:0]`. It mirrors the `PISO` used by the transmitter.
- The baud counter, bit index and FSM live in `uart_rx`.

## Test plan
- Basic byte, C = 16: frame 0xA5 with `rx_i_ready` = 0.
  - `rx_o_data_valid` rises at E0+154 with `rx_o_data` = 0xA5 and holds.
  - Pulse `rx_i_ready`: valid drops the next cycle.
- False start: `rx_i` low for 3 cycles, then high. No valid, no frame_err, FSM back in IDLE.
- Framing error: send 0x3C with the stop bit driven low.
  - `rx_o_frame_err` is a 1-cycle pulse at E0+154; valid stays 0.
  - With the line still low, no re-arm occurs.
  - After the line goes high, frame 0x81 is received correctly.
- Overrun: back-to-back frames 0x55 then 0x19 with `rx_i_ready` = 0.
  - `rx_o_data` stays 0x55; `rx_o_overrun` pulses at the second commit.
  - Repeat with `rx_i_ready` = 1 exactly at the second commit edge: `rx_o_data` = 0x19, no overrun.
- Enable drop: deassert `rx_en` during data bit 3 of 0xAA, then re-enable and send 0x19. Only 0x19 is delivered; no frame_err.
- Reset mid-frame: assert `rx_rst` during bit 5. All outputs are 0 immediately; a following frame 0xF0 is received normally.
